// File: rtl/serial_addsub_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_addsub_ctrl_pkg
//   Shared definitions for the bit-serial adder/subtractor sequencer:
//   FSM state encodings and operation codes.
//   No ports (package).
// -----------------------------------------------------------------------------
package serial_addsub_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage : serial_addsub_ctrl_pkg

// File: rtl/serial_addsub_ctrl_addsub_bit.sv
// -----------------------------------------------------------------------------
// addsub_bit
//   Purely combinational 1-bit full adder used as the serial datapath slice.
//   Any operand inversion for subtraction is done by the controller.
// Ports
//   x, y  in   operand bits
//   ci    in   carry in
//   s     out  sum bit
//   co    out  carry out
// -----------------------------------------------------------------------------
module addsub_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule : addsub_bit

// File: rtl/serial_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_addsub_ctrl
//   Bit-serial WIDTH-bit adder/subtractor sequencer. Feeds one addsub_bit
//   slice LSB-first, keeps the running carry in a flop and assembles the
//   result over WIDTH cycles. Subtraction is a + ~b + 1.
//
//   Optional feature macro: OVF_FLAG_EN
//     defined   : ovf reports signed overflow (carry into MSB ^ final carry)
//     undefined : ovf is tied to 0, no overflow flop is built
//
// Ports
//   clk     in   clock, rising edge
//   rst_n   in   synchronous active-low reset
//   start   in   operation request, sampled only in IDLE
//   op      in   0 = add, 1 = subtract (captured with start)
//   a, b    in   WIDTH-bit operands (captured with start)
//   busy    out  high while the serial loop runs
//   done    out  one-cycle pulse when result/cout/ovf become valid
//   result  out  WIDTH-bit sum/difference, held until the next done
//   cout    out  final carry (sub: 1 = no borrow)
//   ovf     out  signed overflow flag
// -----------------------------------------------------------------------------
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;

    logic             sum_bit;
    logic             carry_d;
    logic [WIDTH-1:0] acc_d;

    addsub_bit u_slice (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .ci (carry_q),
        .s  (sum_bit),
        .co (carry_d)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at acc[0].
    assign acc_d = {sum_bit, acc_q[WIDTH-1:1]};

`ifdef OVF_FLAG_EN
    logic ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
`ifdef OVF_FLAG_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= (op == OP_SUB) ? ~b : b;
                        carry_q <= (op == OP_SUB);
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end

                S_RUN: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    acc_q   <= acc_d;
                    carry_q <= carry_d;
                    if (cnt_q == CNT_LAST) begin
                        // Outputs are loaded on the edge into DONE so they are
                        // already valid during the done pulse. carry_q here is
                        // the carry into the MSB.
                        result_q <= acc_d;
                        cout_q   <= carry_d;
`ifdef OVF_FLAG_EN
                        ovf_q    <= carry_q ^ carry_d;
`endif
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    // start is deliberately not looked at here.
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
`ifdef OVF_FLAG_EN
    assign ovf    = ovf_q;
`else
    assign ovf    = 1'b0;
`endif

endmodule : serial_addsub_ctrl

// File: tb/tb_serial_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub_ctrl
//   Self-checking bench for serial_addsub_ctrl (WIDTH=8). Expected values
//   come from an integer-arithmetic model of add/sub, carry and signed range.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_addsub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [W-1:0] held_res = '0;
    int last_done_cyc = 0;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic o, output logic [W-1:0] r,
                                  output logic c, output logic v);
        longint ua, ub, sa, sb, s, sr, lim;
        ua  = longint'(av);
        ub  = longint'(bv);
        lim = longint'(1) << (W - 1);
        sa  = av[W-1] ? ua - (longint'(1) << W) : ua;
        sb  = bv[W-1] ? ub - (longint'(1) << W) : ub;
        if (o == 1'b0) begin
            s  = ua + ub;
            sr = sa + sb;
            c  = (s >= (longint'(1) << W));
        end else begin
            s  = ua - ub;
            sr = sa - sb;
            c  = (ua >= ub);
        end
        s = s & ((longint'(1) << W) - 1);
        r = W'(s);
`ifdef OVF_FLAG_EN
        v = (sr >= lim) || (sr < -lim);
`else
        v = 1'b0;
`endif
    endfunction

    // Runs one operation starting in the next cycle; returns in the done cycle.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic o);
        logic [W-1:0] er;
        logic ec, ev;
        model(av, bv, o, er, ec, ev);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_done: done=%b required 0", done);
        end
        start = 1'b1; a = av; b = bv; op = o;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0;
                a = W'($urandom); b = W'($urandom); op = 1'($urandom);
            end
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0 || result !== held_res) begin
                n_fail++;
                $display("FAIL run_cycle%0d: busy=%b done=%b result=%h required busy=1 done=0 result=%h",
                         i + 1, busy, done, result, held_res);
            end
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== er || cout !== ec || ovf !== ev) begin
            n_fail++;
            $display("FAIL op %h%s%h: done=%b busy=%b result=%h cout=%b ovf=%b required done=1 busy=0 result=%h cout=%b ovf=%b",
                     av, o ? "-" : "+", bv, done, busy, result, cout, ovf, er, ec, ev);
        end else begin
            $display("op %h%s%h -> result=%h cout=%b ovf=%b", av, o ? "-" : "+", bv, result, cout, ovf);
        end
        held_res = er;
        last_done_cyc = cyc;
    endtask

    // Watches n cycles and requires neither busy nor done to appear.
    task automatic expect_quiet(input int n, input string name);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy === 1'b1 || done === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL %s: %0d active cycles seen, required 0", name, seen);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b result=%h cout=%b ovf=%b required all 0",
                     busy, done, result, cout, ovf);
        end
        rst_n = 1'b1;
        held_res = '0;
    endtask

    task automatic test_directed();
        do_op(8'h3C, 8'h15, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0);
        do_op(8'h05, 8'h07, 1'b1);
        do_op(8'h80, 8'h01, 1'b1);
        do_op(8'h00, 8'h00, 1'b1);
        do_op(8'h80, 8'h80, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++)
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h10; op = 1'b0;
        for (int i = 1; i <= W + 1; i++) begin
            @(negedge clk);
            start = (i == 3 || i == W + 1);
            if (start) begin a = 8'hAA; b = 8'h01; op = 1'b1; end
            if (done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 1 || result !== 8'h20) begin
            n_fail++;
            $display("FAIL ignore_start: dones=%0d result=%h required dones=1 result=20", dones, result);
        end
        @(negedge clk);
        start = 1'b0;
        held_res = 8'h20;
        expect_quiet(12, "ignore_start_no_second_op");
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        start = 1'b1; a = 8'h33; b = 8'h44; op = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: busy=%b done=%b result=%h required 0 0 00", busy, done, result);
        end
        held_res = '0;
        expect_quiet(15, "aborted_op_done");
        do_op(8'h12, 8'h34, 1'b0);
    endtask

    task automatic test_back_to_back();
        int prev;
        do_op(8'h01, 8'h02, 1'b0);
        prev = last_done_cyc;
        do_op(8'h90, 8'h10, 1'b1);
        n_checks++;
        if (last_done_cyc - prev != W + 2) begin
            n_fail++;
            $display("FAIL back_to_back_spacing: %0d cycles required %0d", last_done_cyc - prev, W + 2);
        end
        prev = last_done_cyc;
        do_op(8'hC0, 8'h50, 1'b0);
        n_checks++;
        if (last_done_cyc - prev != W + 2) begin
            n_fail++;
            $display("FAIL back_to_back_spacing2: %0d cycles required %0d", last_done_cyc - prev, W + 2);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_midrun();
        test_back_to_back();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_serial_addsub_ctrl
